// File: rtl/matrix_scan_pkg.sv
// Shared constants, state encoding and the display-duration helper for the HUB75 scan sequencer.
package matrix_scan_pkg;

    localparam int COLUMNS      = 64;
    localparam int ROWS         = 16;
    localparam int BITPLANES    = 6;
    localparam int DISPLAY_BASE = 16;
    localparam int LATCH_CYCLES = 2;
    localparam int BLANK_CYCLES = 1;

    localparam int COL_W   = $clog2(COLUMNS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int TIMER_W = $clog2(DISPLAY_BASE << (BITPLANES - 1));

    typedef logic [1:0] state_t;
    localparam state_t SHIFT   = 2'd0;
    localparam state_t BLANK   = 2'd1;
    localparam state_t LATCH   = 2'd2;
    localparam state_t DISPLAY = 2'd3;

    // Timer reload value (duration minus one) for the plane selected by a one-hot mask.
    function automatic logic [TIMER_W-1:0] display_load(input logic [BITPLANES-1:0] mask);
        int cycles;
        cycles = DISPLAY_BASE;
        for (int i = 0; i < BITPLANES; i++) begin
            if (mask[i]) cycles = DISPLAY_BASE << i;
        end
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a load of N-1 gives an N-cycle interval.
module matrix_scan_timer
    import matrix_scan_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // NOTE: registers are written with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/matrix_scan.sv
// HUB75 1/16-scan sequencer: shifts a row, blanks, latches, then displays it for a binary-weighted time per bit plane.
module matrix_scan
    import matrix_scan_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 reset,
    output logic [COL_W-1:0]     column_address,
    output logic [ROW_W-1:0]     row_address,
    output logic [ROW_W-1:0]     row_address_active,
    output logic                 clk_pixel_load,
    output logic                 clk_pixel,
    output logic                 row_latch,
    output logic                 output_enable,
    output logic [BITPLANES-1:0] brightness_mask
);

    state_t             state;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;
    logic               last_column;

    assign last_column = (column_address == COL_W'(COLUMNS - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            SHIFT: if (clk_pixel && last_column) begin
                timer_load  = 1'b1;
                timer_value = TIMER_W'(BLANK_CYCLES - 1);
            end
            BLANK: if (timer_done) begin
                timer_load  = 1'b1;
                timer_value = TIMER_W'(LATCH_CYCLES - 1);
            end
            LATCH: if (timer_done) begin
                timer_load  = 1'b1;
                timer_value = display_load(brightness_mask);
            end
            default: ;
        endcase
    end

    matrix_scan_timer u_timer (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // In SHIFT, clk_pixel doubles as the half-cycle phase bit: load marks cycle A, clk_pixel cycle B.
    // Neither being set only happens on the first cycle out of reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state              <= SHIFT;
            column_address     <= '0;
            row_address        <= '0;
            row_address_active <= '0;
            clk_pixel_load     <= 1'b0;
            clk_pixel          <= 1'b0;
            row_latch          <= 1'b0;
            output_enable      <= 1'b0;
            brightness_mask    <= BITPLANES'(1);
        end else begin
            case (state)
                SHIFT: begin
                    if (clk_pixel_load) begin
                        clk_pixel_load <= 1'b0;
                        clk_pixel      <= 1'b1;
                    end else if (clk_pixel) begin
                        clk_pixel <= 1'b0;
                        if (last_column) begin
                            state <= BLANK;
                        end else begin
                            column_address <= column_address + 1'b1;
                            clk_pixel_load <= 1'b1;
                        end
                    end else begin
                        clk_pixel_load <= 1'b1;
                    end
                end
                BLANK: if (timer_done) begin
                    state              <= LATCH;
                    row_latch          <= 1'b1;
                    row_address_active <= row_address;
                end
                LATCH: if (timer_done) begin
                    state         <= DISPLAY;
                    row_latch     <= 1'b0;
                    output_enable <= 1'b1;
                end
                DISPLAY: if (timer_done) begin
                    state           <= SHIFT;
                    output_enable   <= 1'b0;
                    column_address  <= '0;
                    clk_pixel_load  <= 1'b1;
                    brightness_mask <= {brightness_mask[BITPLANES-2:0], brightness_mask[BITPLANES-1]};
                    if (brightness_mask[BITPLANES-1]) begin
                        row_address <= (row_address == ROW_W'(ROWS - 1)) ? '0 : row_address + 1'b1;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: per-plane expectations are queued at reset release and compared as each plane completes.
module tb_matrix_scan;
    import matrix_scan_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [5:0] column_address;
    logic [3:0] row_address;
    logic [3:0] row_address_active;
    logic       clk_pixel_load;
    logic       clk_pixel;
    logic       row_latch;
    logic       output_enable;
    logic [5:0] brightness_mask;

    matrix_scan dut (
        .clk_in             (clk_in),
        .reset              (reset),
        .column_address     (column_address),
        .row_address        (row_address),
        .row_address_active (row_address_active),
        .clk_pixel_load     (clk_pixel_load),
        .clk_pixel          (clk_pixel),
        .row_latch          (row_latch),
        .output_enable      (output_enable),
        .brightness_mask    (brightness_mask)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cycles;
        int shift_len;
        int rises;
        int loads;
        int seq_err;
        int blank_len;
        int latch_len;
        int row_active;
        int oe_len;
        int mask;
        int row;
        int const_err;
        int timeout;
    } plane_t;

    plane_t exp_q[$];
    int n_compared    = 0;
    int n_mismatched  = 0;
    int viol_oe_latch = 0;
    int viol_clk      = 0;
    int total_cycles  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Invariants sampled every cycle while running.
    always @(negedge clk_in) begin
        if (reset === 1'b1) begin
            if (output_enable && row_latch) viol_oe_latch++;
            if (clk_pixel && dut.state != SHIFT) viol_clk++;
        end
    end

    task automatic push_expected(input int r, input int b);
        plane_t e;
        e.cycles     = 131 + (16 << b);
        e.shift_len  = 128;
        e.rises      = 64;
        e.loads      = 64;
        e.seq_err    = 0;
        e.blank_len  = 1;
        e.latch_len  = 2;
        e.row_active = r;
        e.oe_len     = 16 << b;
        e.mask       = 1 << b;
        e.row        = r;
        e.const_err  = 0;
        e.timeout    = 0;
        exp_q.push_back(e);
    endtask

    // Starts on the first SHIFT sample of a plane, returns on the first sample of the next one.
    task automatic measure_plane(output plane_t m);
        int   exp_col;
        logic prev_load;
        logic prev_clk;
        m = '{default: 0};
        m.mask    = int'(brightness_mask);
        m.row     = int'(row_address);
        exp_col   = 0;
        prev_load = 1'b0;
        prev_clk  = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            m.cycles++;
            if (int'(brightness_mask) != m.mask || int'(row_address) != m.row) m.const_err++;
            if (clk_pixel_load || clk_pixel) begin
                m.shift_len++;
                if (clk_pixel_load) begin
                    m.loads++;
                    if (int'(column_address) != exp_col) m.seq_err++;
                    exp_col++;
                end
                if (clk_pixel && !prev_clk) begin
                    m.rises++;
                    if (!prev_load) m.seq_err++;
                end
            end else if (row_latch) begin
                m.latch_len++;
                m.row_active = int'(row_address_active);
            end else if (output_enable) begin
                m.oe_len++;
            end else if (m.oe_len == 0) begin
                m.blank_len++;
            end
            prev_load = clk_pixel_load;
            prev_clk  = clk_pixel;
            @(negedge clk_in);
            if (m.oe_len > 0 && !output_enable) return;
        end
        m.timeout = 1;
    endtask

    task automatic compare_plane(input int idx, input plane_t m);
        plane_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("p%0d.scoreboard_empty", idx), 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("p%0d.timeout", idx),    m.timeout,    e.timeout);
        check($sformatf("p%0d.cycles", idx),     m.cycles,     e.cycles);
        check($sformatf("p%0d.shift_len", idx),  m.shift_len,  e.shift_len);
        check($sformatf("p%0d.pixel_rises", idx), m.rises,     e.rises);
        check($sformatf("p%0d.loads", idx),      m.loads,      e.loads);
        check($sformatf("p%0d.seq_err", idx),    m.seq_err,    e.seq_err);
        check($sformatf("p%0d.blank_len", idx),  m.blank_len,  e.blank_len);
        check($sformatf("p%0d.latch_len", idx),  m.latch_len,  e.latch_len);
        check($sformatf("p%0d.row_active", idx), m.row_active, e.row_active);
        check($sformatf("p%0d.oe_len", idx),     m.oe_len,     e.oe_len);
        check($sformatf("p%0d.mask", idx),       m.mask,       e.mask);
        check($sformatf("p%0d.row", idx),        m.row,        e.row);
        check($sformatf("p%0d.const_err", idx),  m.const_err,  e.const_err);
    endtask

    initial begin
        plane_t m;
        reset = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst.column_address", column_address, 0);
        check("rst.row_address", row_address, 0);
        check("rst.row_address_active", row_address_active, 0);
        check("rst.clk_pixel_load", clk_pixel_load, 0);
        check("rst.clk_pixel", clk_pixel, 0);
        check("rst.row_latch", row_latch, 0);
        check("rst.output_enable", output_enable, 0);
        check("rst.brightness_mask", brightness_mask, 6'b000001);

        reset = 1'b1;
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < 6; b++) push_expected(r, b);
        @(negedge clk_in);
        check("start.column_address", column_address, 0);
        check("start.clk_pixel_load", clk_pixel_load, 1);
        check("start.clk_pixel", clk_pixel, 0);

        // One full frame: 16 rows x 6 planes.
        for (int p = 0; p < 96; p++) begin
            measure_plane(m);
            total_cycles += m.cycles;
            compare_plane(p, m);
        end
        check("frame.cycles", total_cycles, 28704);
        check("frame.row_address", row_address, 0);
        check("frame.brightness_mask", brightness_mask, 6'b000001);
        check("frame.column_address", column_address, 0);
        check("frame.clk_pixel_load", clk_pixel_load, 1);

        // Run on into row 1, plane 3, then reset in the middle of its DISPLAY.
        for (int b = 0; b < 6; b++) push_expected(0, b);
        for (int b = 0; b < 3; b++) push_expected(1, b);
        for (int p = 96; p < 105; p++) begin
            measure_plane(m);
            compare_plane(p, m);
        end
        for (int i = 0; i < 200 && !output_enable; i++) @(negedge clk_in);
        check("p3.display_reached", output_enable, 1);
        repeat (20) @(negedge clk_in);
        check("p3.brightness_mask", brightness_mask, 6'b001000);
        check("p3.row_address", row_address, 1);
        check("p3.row_address_active", row_address_active, 1);
        check("p3.output_enable", output_enable, 1);

        reset = 1'b0;
        @(negedge clk_in);
        check("abort.output_enable", output_enable, 0);
        check("abort.row_address", row_address, 0);
        check("abort.row_address_active", row_address_active, 0);
        check("abort.brightness_mask", brightness_mask, 6'b000001);
        check("abort.column_address", column_address, 0);
        check("abort.row_latch", row_latch, 0);
        check("abort.clk_pixel", clk_pixel, 0);
        check("abort.clk_pixel_load", clk_pixel_load, 0);

        reset = 1'b1;
        @(negedge clk_in);
        check("restart.clk_pixel_load", clk_pixel_load, 1);
        check("restart.column_address", column_address, 0);

        check("inv.oe_and_latch", viol_oe_latch, 0);
        check("inv.clk_pixel_outside_shift", viol_clk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
